// File: rtl/cpu_core.sv
// Two-phase 8-bit accumulator CPU: FETCH presents pc on adr, EXEC commits the fetched instruction.
// Optional DEBUG_MODE_EN exposes r0..r7 on debug_regs.
module cpu_core (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        btn,
  input  logic [23:0]       counter,
  input  logic [7:0]        dout,
  output logic [3:0]        adr,
  output logic [3:0]        led,
  output logic [7:0]        col,
  output logic [7:0]        row
`ifdef DEBUG_MODE_EN
  ,
  output logic [7:0][7:0]   debug_regs
`endif
);

  typedef enum logic {FETCH, EXEC} phase_t;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] n;
  } inst_t;

  phase_t          phase, phase_nxt;
  logic [3:0]      pc, pc_nxt;
  logic [7:0][7:0] regs, regs_nxt;
  logic            c_flag, c_nxt;
  logic            z_flag, z_nxt;

  inst_t           inst;
  logic [2:0]      rx;
  logic [7:0]      imm;
  logic [7:0]      add_a, add_b;
  logic [8:0]      sum;
  logic            unused_counter;

  assign inst = inst_t'(dout);
  assign rx   = inst.n[2:0];
  assign imm  = {4'b0, inst.n};

  // One adder serves ADD A,n / ADD B,n / ADD A,Rx
  assign add_a = (inst.op == 4'h5) ? regs[1] : regs[0];
  assign add_b = (inst.op == 4'hA) ? regs[rx] : imm;
  assign sum   = {1'b0, add_a} + {1'b0, add_b};

  assign unused_counter = ^counter[15:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      phase  <= FETCH;
      pc     <= '0;
      regs   <= '0;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else begin
      phase  <= phase_nxt;
      pc     <= pc_nxt;
      regs   <= regs_nxt;
      c_flag <= c_nxt;
      z_flag <= z_nxt;
    end
  end

  always_comb begin
    phase_nxt = phase;
    pc_nxt    = pc;
    regs_nxt  = regs;
    c_nxt     = c_flag;
    z_nxt     = z_flag;
    case (phase)
      FETCH: phase_nxt = EXEC;
      EXEC: begin
        phase_nxt = FETCH;
        pc_nxt    = pc + 4'd1;
        case (inst.op)
          4'h0: begin regs_nxt[0] = sum[7:0]; c_nxt = sum[8]; z_nxt = (sum[7:0] == 8'd0); end
          4'h1: regs_nxt[0] = regs[1];
          4'h2: regs_nxt[0] = {4'b0, btn};
          4'h3: regs_nxt[0] = imm;
          4'h4: regs_nxt[1] = regs[0];
          4'h5: begin regs_nxt[1] = sum[7:0]; c_nxt = sum[8]; z_nxt = (sum[7:0] == 8'd0); end
          4'h6: regs_nxt[1] = {4'b0, btn};
          4'h7: regs_nxt[1] = imm;
          4'h8: regs_nxt[rx] = regs[0];
          4'h9: regs_nxt[0] = regs[rx];
          4'hA: begin regs_nxt[0] = sum[7:0]; c_nxt = sum[8]; z_nxt = (sum[7:0] == 8'd0); end
          4'hB: regs_nxt[6] = imm;
          4'hC: regs_nxt[0] = counter[23:16];
          4'hD: if (!c_flag) pc_nxt = inst.n;
          4'hE: if (z_flag)  pc_nxt = inst.n;
          4'hF: pc_nxt = inst.n;
          default: ;
        endcase
      end
      default: phase_nxt = FETCH;
    endcase
  end

  assign adr = pc;
  assign led = regs[6][3:0];
  assign col = regs[4];
  assign row = regs[5];

`ifdef DEBUG_MODE_EN
  assign debug_regs = regs;
`endif

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: small programs in a synchronous-read memory, results observed on adr/led/col/row.
module tb_cpu_core;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  btn = 4'h0;
  logic [23:0] counter = 24'h0;
  logic [7:0]  dout;
  logic [3:0]  adr, led;
  logic [7:0]  col, row;
`ifdef DEBUG_MODE_EN
  logic [7:0][7:0] debug_regs;
`endif

  logic [7:0] mem [16];
  int checks = 0;
  int failures = 0;

  cpu_core dut (
    .clk(clk), .reset(reset), .btn(btn), .counter(counter), .dout(dout),
    .adr(adr), .led(led), .col(col), .row(row)
`ifdef DEBUG_MODE_EN
    , .debug_regs(debug_regs)
`endif
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) dout <= mem[adr];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 16; i++) mem[i] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    int edges;

    // Reset with arbitrary memory contents
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h5A + i * 17);
    step(3);
    do_reset();
    chk("rst_adr", adr, 0);
    chk("rst_led", led, 0);
    chk("rst_col", col, 0);
    chk("rst_row", row, 0);
`ifdef DEBUG_MODE_EN
    chk("rst_dbg", debug_regs, 0);
`endif

    // Immediate moves: MOV A,2; OUT 1; MOV B,3; MOV R4,A; MOV A,R1; MOV R5,A; JMP 6
    fill(8'h00);
    mem[0] = 8'h32; mem[1] = 8'hB1; mem[2] = 8'h73; mem[3] = 8'h84;
    mem[4] = 8'h91; mem[5] = 8'h85; mem[6] = 8'hF6;
    do_reset();
    chk("imm_adr0", adr, 0);
    step(1); chk("imm_adr1", adr, 0);
    step(1); chk("imm_adr2", adr, 1);
    step(1); chk("imm_adr3", adr, 1);
    step(1); chk("imm_adr4", adr, 2); chk("imm_led", led, 4'b0001);
    step(1); chk("imm_adr5", adr, 2);
    step(3); chk("imm_col_a2", col, 8'h02);
    step(4); chk("imm_row_b3", row, 8'h03);

    // Carry loop: A=0x0F then ADD 0x0F / JNC 1 until carry; A ends at 0x0E after 36 instructions
    fill(8'h00);
    mem[0] = 8'h3F; mem[1] = 8'h0F; mem[2] = 8'hD1; mem[3] = 8'h84; mem[4] = 8'hF4;
    do_reset();
    step(6); chk("jnc_taken_adr", adr, 1);
    edges = 6;
    while (col == 8'h00 && edges < 300) begin
      step(1);
      edges++;
    end
    chk("jnc_edges", edges, 72);
    chk("jnc_col", col, 8'h0E);

    // Zero flag: MOV A,0; ADD A,0; JZ 5 taken
    fill(8'h00);
    mem[0] = 8'h30; mem[1] = 8'h00; mem[2] = 8'hE5; mem[3] = 8'hB3; mem[4] = 8'hF4;
    mem[5] = 8'hB7; mem[6] = 8'hF6;
    do_reset();
    step(6); chk("jz_taken_adr", adr, 5);
    step(2); chk("jz_taken_led", led, 7);

    // A=1 clears Z; MOV A,0 must not set it, so JZ 6 falls through
    mem[0] = 8'h31; mem[1] = 8'h00; mem[2] = 8'h30; mem[3] = 8'hE6; mem[4] = 8'hB3;
    mem[5] = 8'hF5; mem[6] = 8'hB7; mem[7] = 8'hF7;
    do_reset();
    step(8); chk("jz_not_adr", adr, 4);
    step(2); chk("jz_not_led", led, 3);

    // I/O paths and register-operand adds
    fill(8'h00);
    btn = 4'b1010;
    counter = 24'hA5_1234;
    mem[0]  = 8'h20; mem[1]  = 8'h84; mem[2]  = 8'hC0; mem[3]  = 8'h85;
    mem[4]  = 8'h60; mem[5]  = 8'h91; mem[6]  = 8'h86; mem[7]  = 8'hA4;
    mem[8]  = 8'h85; mem[9]  = 8'h55; mem[10] = 8'h11; mem[11] = 8'h86;
    mem[12] = 8'hFC;
    do_reset();
    step(4);  chk("io_col_btn", col, 8'h0A);
    step(4);  chk("io_row_ldc", row, 8'hA5);
    step(6);  chk("io_led_inb", led, 4'hA);
    step(4);  chk("io_row_addrx", row, 8'h14);
    step(6);  chk("io_led_addb", led, 4'hF);

    // PC wrap: ADD A,1 everywhere except MOV R4,A at 14
    fill(8'h01);
    mem[14] = 8'h84;
    do_reset();
    step(30); chk("wrap_col", col, 8'h0E);
    step(1);  chk("wrap_adr15", adr, 15);
    step(1);  chk("wrap_adr0", adr, 0);

    // Reset asserted during EXEC of OUT 9 discards it
    fill(8'h00);
    mem[0] = 8'h3F; mem[1] = 8'h84; mem[2] = 8'hB9; mem[3] = 8'hF3;
    do_reset();
    step(4); chk("mid_col_pre", col, 8'h0F);
    step(1); chk("mid_adr_exec", adr, 2);
    reset = 1'b1;
    step(1);
    chk("mid_led", led, 0);
    chk("mid_col", col, 0);
    chk("mid_adr", adr, 0);
    reset = 1'b0;
    step(1); chk("mid_rel_adr1", adr, 0);
    step(1); chk("mid_rel_adr2", adr, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
